// File: rtl/gray_position_tracker.sv
// gray_position_tracker
//   Samples a Gray-coded position word on each gray_valid strobe. It decodes
//   the word to binary and classifies the change against the previous sample
//   as +1, -1, no move or an illegal jump. From that it maintains a signed
//   multi-turn position and a saturating count of illegal jumps.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   gray_in    Gray-coded sample (WIDTH)
//   gray_valid sample gray_in on this edge
//   clear      synchronous return to post-reset state (beats gray_valid)
//   bin_out    binary decode of last accepted sample
//   pos        accumulated two's-complement position (POS_W)
//   step_up    one-cycle pulse, +1 step accepted
//   step_dn    one-cycle pulse, -1 step accepted
//   err        one-cycle pulse, illegal jump detected
//   err_count  saturating illegal-jump count (ERR_W)
//   locked     a reference sample is held
module gray_position_tracker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 16,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] bin_out,
  output logic [POS_W-1:0] pos,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             locked
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [ERR_W-1:0] errc_q, errc_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] bin_new;
  logic [WIDTH-1:0] diff;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    bin_new = '0;
    bin_new[WIDTH-1] = gray_in[WIDTH-1];
    for (int unsigned k = 1; k < WIDTH; k++) begin
      bin_new[WIDTH-1-k] = bin_new[WIDTH-k] ^ gray_in[WIDTH-1-k];
    end
  end

  // bin_q doubles as the reference sample. Modulo subtraction makes the
  // wrap from all-ones to 0 read as +1, and the wrap from 0 to all-ones as -1.
  assign diff = bin_new - bin_q;

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    pos_d   = pos_q;
    errc_d  = errc_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    err_d   = 1'b0;

    if (clear) begin
      state_d = UNLOCKED;
      bin_d   = '0;
      pos_d   = '0;
      errc_d  = '0;
    end else if (gray_valid) begin
      bin_d = bin_new;
      case (state_q)
        UNLOCKED: state_d = LOCKED;
        LOCKED: begin
          if (diff == WIDTH'(1)) begin
            pos_d = pos_q + POS_W'(1);
            up_d  = 1'b1;
          end else if (diff == '1) begin
            pos_d = pos_q - POS_W'(1);
            dn_d  = 1'b1;
          end else if (diff != '0) begin
            err_d = 1'b1;
            if (errc_q != '1) begin
              errc_d = errc_q + ERR_W'(1);
            end
          end
        end
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      bin_q   <= '0;
      pos_q   <= '0;
      errc_q  <= '0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      pos_q   <= pos_d;
      errc_q  <= errc_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      err_q   <= err_d;
    end
  end

  assign bin_out   = bin_q;
  assign pos       = pos_q;
  assign step_up   = up_q;
  assign step_dn   = dn_q;
  assign err       = err_q;
  assign err_count = errc_q;
  assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_gray_position_tracker.sv
// Testbench for gray_position_tracker (WIDTH=4, POS_W=16, ERR_W=8).
module tb_gray_position_tracker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  gray_in;
  logic        gray_valid;
  logic        clear;
  logic [3:0]  bin_out;
  logic [15:0] pos;
  logic        step_up, step_dn, err;
  logic [7:0]  err_count;
  logic        locked;

  int total = 0;
  int bad   = 0;

  // Reference model state. The held binary sample also serves as the reference.
  bit m_locked;
  int m_bin, m_pos, m_errc;
  bit m_up, m_dn, m_err;

  gray_position_tracker #(.WIDTH(4), .POS_W(16), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .gray_valid(gray_valid),
    .clear(clear), .bin_out(bin_out), .pos(pos), .step_up(step_up),
    .step_dn(step_dn), .err(err), .err_count(err_count), .locked(locked)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input int b);
    int v;
    v = b & 15;
    return 4'(v ^ (v >> 1));
  endfunction

  task automatic model_reset();
    m_locked = 0; m_bin = 0; m_pos = 0; m_errc = 0;
    m_up = 0; m_dn = 0; m_err = 0;
  endtask

  task automatic model(input int b, input bit v, input bit c);
    int d;
    m_up = 0; m_dn = 0; m_err = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      b = b & 15;
      if (m_locked) begin
        d = (b - m_bin + 16) % 16;
        if (d == 1) begin
          m_pos = (m_pos + 1) % 65536; m_up = 1;
        end else if (d == 15) begin
          m_pos = (m_pos + 65535) % 65536; m_dn = 1;
        end else if (d != 0) begin
          m_err = 1;
          if (m_errc < 255) m_errc = m_errc + 1;
        end
      end
      m_locked = 1;
      m_bin = b;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("bin_out",   32'(bin_out),   32'(m_bin));
    chk("pos",       32'(pos),       32'(m_pos));
    chk("step_up",   32'(step_up),   32'(m_up));
    chk("step_dn",   32'(step_dn),   32'(m_dn));
    chk("err",       32'(err),       32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_errc));
    chk("locked",    32'(locked),    32'(m_locked));
  endtask

  // Drive one cycle of stimulus (given as a binary position) and check after the edge.
  task automatic step(input int b, input bit v, input bit c);
    gray_in = to_gray(b); gray_valid = v; clear = c;
    model(b, v, c);
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    int b, r;
    bit v, c;

    // Reset held while a sample is offered.
    rst_n = 0; gray_valid = 1; gray_in = 4'b0110; clear = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_all();
    rst_n = 1;

    // Lock at 0, then count up.
    step(0, 1, 0);
    step(1, 1, 0); step(2, 1, 0); step(3, 1, 0);
    chk("up_pos3", 32'(pos), 32'd3);
    step(3, 0, 0);
    step(3, 1, 0);

    // Wrap and down.
    step(0, 0, 1);
    step(15, 1, 0);
    step(0, 1, 0);
    step(15, 1, 0);
    step(14, 1, 0);
    chk("neg_pos", 32'(pos), 32'h0000FFFF);

    // Illegal jumps.
    step(0, 0, 1);
    step(0, 1, 0);
    step(2, 1, 0);
    step(4, 1, 0);
    chk("err2", 32'(err_count), 32'd2);

    // Saturation.
    b = 4;
    for (int i = 0; i < 300; i++) begin
      b = b + 2;
      step(b, 1, 0);
    end
    chk("sat", 32'(err_count), 32'd255);

    // Clear beats valid, then the next sample only locks.
    step(b + 1, 1, 1);
    step(7, 1, 0);
    step(8, 1, 0);

    // Reset mid-run with pos=5.
    step(0, 0, 1);
    step(0, 1, 0);
    for (int i = 1; i <= 5; i++) step(i, 1, 0);
    chk("pos5", 32'(pos), 32'd5);
    gray_valid = 0;
    #2 rst_n = 0;
    model_reset();
    #1 check_all();
    #1 rst_n = 1;
    step(6, 1, 0);
    step(7, 1, 0);

    // Randomised moves: mostly small steps, some holds, jumps, idles and clears.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: b = m_bin + 1;
        3, 4, 5: b = m_bin - 1 + 16;
        6:       b = m_bin;
        default: b = int'($urandom_range(0, 15));
      endcase
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 39) == 0);
      step(b, v, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_position_tracker.md
# gray_position_tracker

Receive-side companion to the team's Gray-code generators. It samples a Gray-coded position word, such as an incremental encoder or a Gray counter output, once per valid strobe. Each accepted word is decoded to binary, classified as a single-step move up or down, and used to maintain a signed multi-turn position. Multi-step jumps are flagged and counted as errors. It sits between a raw Gray source and any consumer that needs a clean binary position with step events.

## Interface
Parameters:
- WIDTH, 4, bit width of the Gray input word (≥2)
- POS_W, 16, width of the accumulated position (two's complement)
- ERR_W, 8, width of the saturating error counter

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  WIDTH  Gray-coded sample
- gray_valid  input  1  gray_in is sampled on this edge when high
- clear  input  1  synchronous clear; returns the block to the post-reset state
- bin_out  output  WIDTH  binary decode of the last accepted sample
- pos  output  POS_W  accumulated position
- step_up  output  1  one-cycle pulse: a +1 step was accepted
- step_dn  output  1  one-cycle pulse: a −1 step was accepted
- err  output  1  one-cycle pulse: an illegal jump was detected
- err_count  output  ERR_W  saturating count of illegal jumps
- locked  output  1  a reference sample is held

## Operation
- Decode: bin[WIDTH-1] = gray[WIDTH-1]; bin[i] = bin[i+1] ^ gray[i] for i down to 0. The decode is purely combinational on gray_in.
- State UNLOCKED (reset state):
  - On gray_valid, capture the decoded value as the reference and drive it on bin_out.
  - Leave pos at 0, set locked=1, generate no pulses, and go to LOCKED.
- State LOCKED: on gray_valid, compute diff = (bin_new − bin_ref) mod 2^WIDTH. Then:
  - diff = 0: no change and no pulses. bin_out is unchanged.
  - diff = 1: pos ← pos+1 and pulse step_up.
  - diff = 2^WIDTH−1: pos ← pos−1 and pulse step_dn.
  - Any other diff: pos is unchanged, err is pulsed, and err_count increments, saturating at 2^ERR_W−1. The reference is re-anchored to bin_new and the block stays LOCKED.
- In every LOCKED case, bin_ref and bin_out take bin_new.
- Input wrap: 2^WIDTH−1 → 0 is a +1 step, and 0 → 2^WIDTH−1 is a −1 step.
- pos arithmetic is modulo 2^POS_W. 0 − 1 gives all-ones, and the maximum positive value + 1 gives the minimum negative value. No overflow flag.
- When gray_valid is low, all state holds and step_up, step_dn and err are 0.
- clear has priority over gray_valid in the same cycle. It sets UNLOCKED, pos=0, bin_out=0, err_count=0 and locked=0, pulses are 0, and the sample is discarded.

## Timing
- Reset values: bin_out=0, pos=0, step_up=0, step_dn=0, err=0, err_count=0, locked=0, state UNLOCKED.
- All outputs are registered. A sample accepted at rising edge N is reflected in bin_out, pos, the pulses, err_count and locked after edge N, so the latency is 1 cycle.
- step_up, step_dn and err are mutually exclusive and each is high for exactly one cycle per accepted sample. Back-to-back valid cycles produce back-to-back pulses.
- gray_valid may be high continuously. There is no backpressure and every valid cycle is consumed.
- Assertion of rst_n low mid-operation forces the reset values immediately, independent of clk. The first valid sample after release only locks.

## Test plan
- Reset: hold rst_n=0 with gray_valid=1 and gray_in=4'b0110 → all outputs at their reset values. After release, gray_in=4'b0000 with valid → locked=1, pos=0, no pulses.
- Count up: from lock at gray 0000, apply 0001, 0011, 0010 (bin 1, 2, 3) → three step_up pulses and pos=3, bin_out=3.
- Wrap and down (WIDTH=4):
  - lock at gray 1000 (bin 15), then apply 0000 → step_up, pos=1;
  - then apply 1000 → step_dn, pos=0;
  - then apply 1001 (bin 14) → step_dn, pos=16'hFFFF.
- Illegal jump: lock at 0000, apply 0011 (bin 2) → err pulse, err_count=1, pos=0, bin_out=2. Then apply 0110 (bin 4) → err again, err_count=2.
- Saturation and clear:
  - 300 illegal jumps → err_count holds 255.
  - Asserting clear together with gray_valid → pos=0, err_count=0, locked=0 and no pulse. The next valid sample only locks.
- Reset mid-run: with pos=5, pulse rst_n low between edges → pos=0 and locked=0 immediately. The first valid sample after release produces no step.
